// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Purpose:
//   Clean front-end for a downstream NAND SR latch. Two raw, bouncy push
//   buttons are synchronised, debounced and edge-detected. Each press becomes
//   one registered active-low pulse on `s` or `r`. The pulses are sequenced so
//   that `s` and `r` can never be low in the same cycle, which keeps the latch
//   out of its forbidden 0/0 input. Presses that collide are dropped and
//   reported on `conflict`.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   set_in    in   raw set button, active-high, asynchronous to clk
//   reset_in  in   raw reset button, active-high, asynchronous to clk
//   s         out  active-low set drive to the latch (registered)
//   r         out  active-low reset drive to the latch (registered)
//   busy      out  high while a pulse or the following gap is in progress
//   conflict  out  one-cycle pulse when set and reset requests collide
// -----------------------------------------------------------------------------
module sr_latch_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic reset_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  typedef enum logic [1:0] {
    IDLE,
    SET_PULSE,
    RESET_PULSE,
    GAP
  } state_e;

  // Channel 0 carries the set button, channel 1 the reset button.
  localparam int CH_SET = 0;
  localparam int CH_RST = 1;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  logic [1:0] raw;
  assign raw = {reset_in, set_in};

  // Synchroniser, debounce and edge-detect state, one bit/counter per channel.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       db_q, db_d;
  logic [1:0]       db_prev_q;
  logic [CNT_W-1:0] db_cnt_q [2];
  logic [CNT_W-1:0] db_cnt_d [2];
  logic [1:0]       req;

  // Sequencer state.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             set_pend_q, set_pend_d;
  logic             rst_pend_q, rst_pend_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;

  // ---------------------------------------------------------------------------
  // Debounce: the level follows sync2 only after DEBOUNCE_CYCLES consecutive
  // differing samples; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A request is a rising edge of the debounced level; releases are silent.
  assign req = db_q & ~db_prev_q;

  // ---------------------------------------------------------------------------
  // Sequencer next state. Pending flags absorb new requests every cycle and
  // are only consumed in IDLE, so a press during a pulse waits its turn and a
  // repeated press merges into the same flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    set_pend_d = set_pend_q | req[CH_SET];
    rst_pend_d = rst_pend_q | req[CH_RST];
    conflict_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (set_pend_d && rst_pend_d) begin
          // Neither order is safe to guess: drop both and report it.
          set_pend_d = 1'b0;
          rst_pend_d = 1'b0;
          conflict_d = 1'b1;
        end else if (set_pend_d) begin
          set_pend_d = 1'b0;
          pcnt_d     = '0;
          state_d    = SET_PULSE;
        end else if (rst_pend_d) begin
          rst_pend_d = 1'b0;
          pcnt_d     = '0;
          state_d    = RESET_PULSE;
        end
      end
      SET_PULSE, RESET_PULSE: begin
        if (pcnt_q == PULSE_LAST) begin
          pcnt_d  = '0;
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered with it, so a
    // single state value drives both pins: s and r cannot both be low.
    s_d    = (state_d != SET_PULSE);
    r_d    = (state_d != RESET_PULSE);
    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // All registers, cleared by the synchronous reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q    <= IDLE;
      pcnt_q     <= '0;
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
      s_q        <= 1'b1;
      r_q        <= 1'b1;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Directed bench for sr_latch_driver with default parameters. Stimulus tasks
// push the expected output changes ({s, r, busy, conflict} and the clock edge
// after which each should appear) into a queue; a monitor watches the outputs
// on the falling edge and pops one entry per observed change.
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic set_in;
  logic reset_in;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  sr_latch_driver #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (2),
    .CNT_W          (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_in  (set_in),
    .reset_in(reset_in),
    .s       (s),
    .r       (r),
    .busy    (busy),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; read on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at_edge;
    logic [3:0] vec;      // {s, r, busy, conflict}
  } exp_t;

  localparam logic [3:0] V_IDLE  = 4'b1100;
  localparam logic [3:0] V_SET   = 4'b0110;
  localparam logic [3:0] V_RST   = 4'b1010;
  localparam logic [3:0] V_GAP   = 4'b1110;
  localparam logic [3:0] V_CONFL = 4'b1101;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cyc);
  endtask

  task automatic expect_ev(input int at_edge, input logic [3:0] vec);
    exp_t e;
    e.at_edge = at_edge;
    e.vec     = vec;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: invariant every cycle, scoreboard pop on every output change.
  // ---------------------------------------------------------------------------
  logic [3:0] prev_vec = V_IDLE;
  always @(negedge clk) begin
    logic [3:0] vec;
    exp_t       e;
    if (mon_en) begin
      vec = {s, r, busy, conflict};
      check("s_r_both_low", 32'({s, r} == 2'b00), 32'd0);
      if (vec !== prev_vec) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", 32'(vec), 32'(prev_vec));
        end else begin
          e = exp_q.pop_front();
          check("event_edge", cyc, e.at_edge);
          check("event_vec", 32'(vec), 32'(e.vec));
        end
        prev_vec = vec;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    rst_n    = 1'b0;
    set_in   = 1'b0;
    reset_in = 1'b0;

    // Reset held for 3 edges while both buttons toggle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_s", s, 1);
      check("reset_r", r, 1);
      check("reset_busy", busy, 0);
      check("reset_conflict", conflict, 0);
      set_in   = ~set_in;
      reset_in = (i % 2 == 0);
    end
    @(negedge clk);
    set_in   = 1'b0;
    reset_in = 1'b0;
    rst_n    = 1'b1;
    mon_en   = 1'b1;
    idle(20);

    // Single set press held 12 cycles: s low after k+6 and k+7.
    @(negedge clk);
    k = cyc + 1;
    set_in = 1'b1;
    expect_ev(k + 6, V_SET);
    expect_ev(k + 8, V_GAP);
    expect_ev(k + 9, V_IDLE);
    idle(12);
    set_in = 1'b0;
    idle(20);

    // Glitchy press: 3 high, 1 low, 3 high, never 4 stable samples.
    @(negedge clk);
    set_in = 1'b1;
    idle(3);
    set_in = 1'b0;
    idle(1);
    set_in = 1'b1;
    idle(3);
    set_in = 1'b0;
    idle(20);

    // Collision: both rise together and are held.
    @(negedge clk);
    k = cyc + 1;
    set_in   = 1'b1;
    reset_in = 1'b1;
    expect_ev(k + 6, V_CONFL);
    expect_ev(k + 7, V_IDLE);
    idle(25);
    set_in   = 1'b0;
    reset_in = 1'b0;
    idle(20);

    // Reset press debounced during the set pulse: queued behind GAP + IDLE.
    @(negedge clk);
    k = cyc + 1;
    set_in = 1'b1;
    expect_ev(k + 6,  V_SET);
    expect_ev(k + 8,  V_GAP);
    expect_ev(k + 9,  V_IDLE);
    expect_ev(k + 10, V_RST);
    expect_ev(k + 12, V_GAP);
    expect_ev(k + 13, V_IDLE);
    idle(1);
    reset_in = 1'b1;
    idle(15);
    set_in   = 1'b0;
    reset_in = 1'b0;
    idle(20);

    // Reset asserted on the second cycle of s low; buttons released meanwhile.
    @(negedge clk);
    k = cyc + 1;
    set_in = 1'b1;
    expect_ev(k + 6, V_SET);
    expect_ev(k + 7, V_IDLE);
    idle(7);
    rst_n  = 1'b0;
    set_in = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(30);

    check("expected_events_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Synchronous front-end that converts two raw, bouncy, asynchronous push-button inputs (set, reset) into clean, registered, active-low pulses sized to drive the `s`/`r` inputs of the NAND SR latch stage directly downstream. It synchronises and debounces each button, detects press events, and sequences them so that `s` and `r` are never low together. This guarantees the latch never sees its forbidden 0/0 input. Simultaneous requests are rejected and flagged.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before a debounced level changes; must be >= 1.
- `PULSE_CYCLES`, default 2: number of cycles an output is held low per request; must be >= 1.
- `CNT_W`, default 8: counter width; must hold max(`DEBOUNCE_CYCLES`, `PULSE_CYCLES`).

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `set_in`, input, 1: raw set button, active-high, asynchronous to `clk`.
- `reset_in`, input, 1: raw reset button, active-high, asynchronous to `clk`.
- `s`, output, 1: active-low set drive to the latch. Registered.
- `r`, output, 1: active-low reset drive to the latch. Registered.
- `busy`, output, 1: high while the FSM is not in IDLE.
- `conflict`, output, 1: one-cycle pulse when set and reset requests collide.

## Operation
- **Reset.** When `rst_n`=0 at a clock edge, every register is cleared at that edge:
  - Synchroniser flops, debounced levels, edge history, debounce counters, pulse counter and pending flags go to 0.
  - State goes to IDLE.
  - Outputs take `s`=1, `r`=1, `busy`=0, `conflict`=0.
  - Reset asserted mid-pulse returns `s`/`r` to 1 at that same edge.
- **Synchroniser.** Each input passes through a 2-flop synchroniser (`sync1` then `sync2`).
- **Debounce, per channel.**
  - If `sync2` differs from the debounced level `db`, the counter increments.
  - If `sync2` equals `db`, the counter clears.
  - On the `DEBOUNCE_CYCLES`-th consecutive differing sample, `db` flips and the counter clears.
  - Any bounce shorter than `DEBOUNCE_CYCLES` samples is ignored.
- **Request.** A request is a rising edge of `db`: `db`=1 and the previous `db`=0. Falling edges generate nothing.
- **Pending flags.**
  - A request sets that channel's pending flag. Servicing the request clears it.
  - A repeated request on the same channel while it is already pending merges into the existing flag and does not queue a second pulse.
- **FSM states:** IDLE, SET_PULSE, RESET_PULSE, GAP.
  - IDLE, both set and reset pending or newly requested → clear both, pulse `conflict` for 1 cycle, stay in IDLE.
  - IDLE, only set → SET_PULSE. Pulse counter loads 0.
  - IDLE, only reset → RESET_PULSE. Pulse counter loads 0.
  - SET_PULSE: `s`=0. Counts `PULSE_CYCLES` cycles, then → GAP.
  - RESET_PULSE: `r`=0. Counts `PULSE_CYCLES` cycles, then → GAP.
  - GAP: `s`=`r`=1 for exactly 1 cycle, then → IDLE.
- **Requests while busy.** A request arriving while the FSM is not in IDLE is only latched as pending. It is evaluated on the next IDLE cycle.
- **Invariant.** `s`=0 and `r`=0 is never true in the same cycle, including across reset and state transitions.

## Timing
- **Set latency, with press first sampled into `sync1` at edge k:**
  - `sync2`=1 after edge k+1.
  - `db`=1 after edge k+1+`DEBOUNCE_CYCLES`.
  - `s`=0 after edge k+2+`DEBOUNCE_CYCLES`.
  - With defaults, `s` goes low after edge k+6.
- **Pulse length.** `s` or `r` is low for exactly `PULSE_CYCLES` consecutive cycles.
- **Back-to-back service.**
  - GAP adds 1 cycle at `s`=`r`=1.
  - One further IDLE cycle is spent evaluating pending flags.
  - Minimum spacing between the end of one pulse and the start of the next is 2 cycles.
- **Status outputs.**
  - `busy` is registered alongside the state and is 1 exactly while the state is SET_PULSE, RESET_PULSE or GAP.
  - `conflict` is high for exactly 1 cycle, on the edge after the colliding evaluation.
- **Release.** A button release produces no output activity. It only re-arms the edge detector after `DEBOUNCE_CYCLES` stable-low samples.

## Test plan
- **Reset values.** Hold `rst_n`=0 for 3 edges with both buttons toggling → `s`=1, `r`=1, `busy`=0, `conflict`=0 throughout. No pulse after release of `rst_n` unless a fresh press is debounced.
- **Single set press.** Defaults, `set_in` high for 12 cycles from edge k → `s`=0 exactly after edges k+6 and k+7, `s`=1 from edge k+8. `r` stays 1. `busy`=1 for 3 cycles.
- **Glitch rejection.** `set_in` high for 3 cycles, low for 1, high for 3, then low → no change on `s`, `r`, `busy`.
- **Collision.** `set_in` and `reset_in` rise in the same cycle and are held → one `conflict` pulse. `s` and `r` stay 1. No pulse follows while both stay held.
- **Queued reset.** `reset_in` press debounced while `s` is low → set pulse completes, GAP, IDLE, then `r`=0 for 2 cycles. No cycle ever has `s`=0 and `r`=0 (checked every cycle by assertion).
- **Reset mid-pulse.** `rst_n`=0 during the second cycle of `s`=0 → `s`=1 at that edge, state IDLE, pending flags cleared. No stale pulse after `rst_n` returns to 1.
